// File: rtl/bram_pkg.sv
// Shared types for the BRAM stream reader.
package bram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/stream_skid2.sv
// Two-entry fall-through buffer: a word pushed into an empty buffer is visible
// on data_out in the same cycle, so the read pipeline adds no extra stage.
module stream_skid2 #(
  parameter int data_width = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [data_width-1:0] data_in,
  input  logic                  last_in,
  input  logic                  pop,
  output logic [data_width-1:0] data_out,
  output logic                  last_out,
  output logic                  valid,
  output logic [1:0]            count
);

  logic [data_width-1:0] mem_q [2];
  logic                  last_q [2];
  logic                  wr_q;
  logic                  rd_q;
  logic [1:0]            count_q;
  logic                  pop_ok;

  assign valid  = (count_q != 2'd0) || push;
  assign pop_ok = pop && valid;
  assign count  = count_q;

  always_comb begin
    data_out = '0;
    last_out = 1'b0;
    if (count_q == 2'd0) begin
      if (push) begin
        data_out = data_in;
        last_out = last_in;
      end
    end else begin
      data_out = mem_q[rd_q];
      last_out = last_q[rd_q];
    end
  end

  // Pointers advance together on a bypassed push+pop, keeping wr == rd when empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      last_q[0] <= 1'b0;
      last_q[1] <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_q]  <= data_in;
        last_q[wr_q] <= last_in;
        wr_q         <= ~wr_q;
      end
      if (pop_ok) begin
        rd_q <= ~rd_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Streams a burst of BRAM words onto a valid/ready interface.
// state | meaning: IDLE wait for start; RUN issue reads and deliver; DRAIN done pulse
module bram_stream_reader
  import bram_pkg::*;
#(
  parameter int addr_width = 8,
  parameter int data_width = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [addr_width-1:0] base_addr,
  input  logic [addr_width:0]   length,
  output logic [addr_width-1:0] raddr,
  input  logic [data_width-1:0] rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [addr_width:0]   CNT_ZERO = '0;
  localparam logic [addr_width:0]   CNT_ONE  = {{addr_width{1'b0}}, 1'b1};
  localparam logic [addr_width-1:0] ADDR_ONE = {{(addr_width-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [addr_width:0]   issue_q, issue_d;
  logic [addr_width:0]   deliver_q, deliver_d;
  logic                  infl_q, infl_d;
  logic                  infl_last_q, infl_last_d;
  logic [addr_width-1:0] raddr_q;
  logic                  issue;
  logic                  pop;
  logic [1:0]            buf_count;
  logic                  buf_valid;
  logic [2:0]            occ;

  stream_skid2 #(.data_width(data_width)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (infl_q),
    .data_in  (rdata),
    .last_in  (infl_last_q),
    .pop      (pop),
    .data_out (out_data),
    .last_out (out_last),
    .valid    (buf_valid),
    .count    (buf_count)
  );

  assign out_valid = buf_valid;
  assign pop       = buf_valid && out_ready;
  assign occ       = {1'b0, buf_count} + {2'b00, infl_q};
  assign raddr     = issue ? addr_q : raddr_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DRAIN);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_d     = issue_q;
    deliver_d   = deliver_q;
    issue       = 1'b0;
    infl_last_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d    = base_addr;
          issue_d   = length;
          deliver_d = length;
          state_d   = (length == CNT_ZERO) ? DRAIN : RUN;
        end
      end
      RUN: begin
        // Occupancy after this cycle must leave room for the word a new read returns.
        if ((issue_q != CNT_ZERO) && (occ <= (3'd1 + {2'b00, pop}))) begin
          issue       = 1'b1;
          addr_d      = addr_q + ADDR_ONE;
          issue_d     = issue_q - CNT_ONE;
          infl_last_d = (issue_q == CNT_ONE);
        end
        if (pop) begin
          deliver_d = deliver_q - CNT_ONE;
          if (deliver_q == CNT_ONE) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    infl_d = issue;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      issue_q     <= '0;
      deliver_q   <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      raddr_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_q     <= issue_d;
      deliver_q   <= deliver_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      raddr_q     <= raddr;
    end
  end

endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter addr_width, default 8, BRAM word address width.
REQ-002 SHALL have parameter data_width, default 16, BRAM read data width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 SHALL have port base_addr  input  addr_width  first word address, captured with start.
REQ-007 SHALL have port length  input  addr_width+1  word count, captured with start; 0 to 2^addr_width.
REQ-008 SHALL have port raddr  output  addr_width  read address driven to the BRAM.
REQ-009 SHALL have port rdata  input  data_width  BRAM read data, valid the cycle after raddr is presented.
REQ-010 SHALL have port out_valid  output  1  out_data holds a word.
REQ-011 SHALL have port out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.
REQ-012 SHALL have port out_data  output  data_width  streamed word.
REQ-013 SHALL have port out_last  output  1  qualifies the final word of the burst.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse at burst completion.

Function
REQ-016 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE; start with length 0 goes IDLE -> DRAIN directly.
REQ-017 SHALL, in IDLE on start, capture base_addr into an address counter and length into an issue counter and a separate delivery counter.
REQ-018 SHALL issue a read in a cycle in RUN when the issue counter is nonzero and (buffered words + in-flight reads - pop this cycle) <= 1.
REQ-019 SHALL, on issue, drive raddr = address counter, increment address modulo 2^addr_width, decrement the issue counter, and set a one-bit in-flight flag for the next cycle.
REQ-020 SHALL, when the in-flight flag is set, write rdata into a 2-entry output buffer in that cycle.
REQ-021 SHALL sustain one word per cycle when out_ready is held high; first out_valid two cycles after the start cycle.
REQ-022 SHALL keep out_data and out_last stable while out_valid && !out_ready; buffer never overflows.
REQ-023 SHALL assert out_last with the word for which the delivery counter equals 1; decrement on each transfer.
REQ-024 SHALL move RUN -> DRAIN on the cycle the final word transfers.
REQ-025 SHALL, in DRAIN, assert done for exactly one cycle and return to IDLE next edge.
REQ-026 SHALL ignore start while busy; no re-capture of base_addr/length.
REQ-027 SHALL wrap addresses: base_addr 0xFE, length 4 reads 0xFE, 0xFF, 0x00, 0x01 (addr_width 8).
REQ-028 SHALL hold raddr at its last value when not issuing (BRAM has no read enable; unused data discarded).

Reset
REQ-029 SHALL on rst asynchronously force state IDLE, counters 0, in-flight flag 0, buffer empty.
REQ-030 SHALL reset outputs: out_valid 0, out_last 0, busy 0, done 0, raddr 0, out_data 0.
REQ-031 SHALL on rst mid-burst discard in-flight and buffered words; first post-reset cycle accepts start.

Structure
REQ-032 SHALL place the FSM state enum (IDLE, RUN, DRAIN) in shared package bram_pkg.
REQ-033 SHALL implement the 2-entry buffer as sub-module stream_skid2 (push, data_in, pop, data_out, last bit, count 0..2).
REQ-034 SHALL contain no memory; it connects to bram raddr/rdata of a single block, read_after_write irrelevant.

Verification
REQ-035 SHALL test: BRAM[i]=i+0x100, start base 0x10 length 4, out_ready=1 -> 0x110..0x113 on four consecutive cycles, out_last on 0x113, done one cycle later.
REQ-036 SHALL test: length 8, out_ready toggled 1,0,0,1,... -> all 8 words in order, none dropped or duplicated, out_data stable while stalled.
REQ-037 SHALL test: base 0xFE length 4 -> raddr sequence 0xFE, 0xFF, 0x00, 0x01 and matching data.
REQ-038 SHALL test: start with length 0 -> no out_valid, done pulse, busy high exactly one cycle.
REQ-039 SHALL test: rst asserted after 3 of 10 words -> outputs at reset values immediately; new burst base 0 length 2 then delivers BRAM[0], BRAM[1] only.
REQ-040 SHALL test: start pulsed mid-burst with different base -> ignored, original burst completes unchanged.
